// File: rtl/mem_arbiter_rr_if.sv
// Bundle of client-side request/response and memory-side signals for mem_arbiter_rr.
// The arbiter takes the slave view; the surrounding fabric or bench takes the master view.
interface mem_arbiter_rr_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]            cl_read;
    logic [NUM_PORTS-1:0]            cl_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] cl_addr;
    logic [NUM_PORTS*LINE_WIDTH-1:0] cl_wdata;
    logic [LINE_WIDTH-1:0]           cl_rdata;
    logic [NUM_PORTS-1:0]            cl_resp;

    logic                            mem_read;
    logic                            mem_write;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [LINE_WIDTH-1:0]           mem_wdata;
    logic [LINE_WIDTH-1:0]           mem_rdata;
    logic                            mem_resp;

    logic                            grant_valid;
    logic [IDX_W-1:0]                grant_idx;

    modport master (
        output cl_read, cl_write, cl_addr, cl_wdata, mem_rdata, mem_resp,
        input  cl_rdata, cl_resp, mem_read, mem_write, mem_addr, mem_wdata,
               grant_valid, grant_idx
    );

    modport slave (
        input  cl_read, cl_write, cl_addr, cl_wdata, mem_rdata, mem_resp,
        output cl_rdata, cl_resp, mem_read, mem_write, mem_addr, mem_wdata,
               grant_valid, grant_idx
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-client cacheline memory arbiter: round-robin or fixed-priority selection,
// latches the winning request for the whole transaction and routes the response back.
module mem_arbiter_rr #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_WIDTH    = 256,
    parameter int PRIORITY_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_rr_if.slave  bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        rr_ptr;
    logic                    op_write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;

    logic [NUM_PORTS-1:0]    req;
    logic [2*NUM_PORTS-1:0]  req_dbl;
    logic [NUM_PORTS-1:0]    req_rot;
    logic [IDX_W-1:0]        search_start;
    logic [IDX_W-1:0]        win;
    logic                    any_req;
    logic                    found;
    int                      win_int;

    assign req          = bus.cl_read | bus.cl_write;
    assign any_req      = |req;
    assign search_start = (PRIORITY_MODE != 0) ? '0 : rr_ptr;
    // Rotating a doubled copy turns the wrap-around search into a plain lowest-bit scan.
    assign req_dbl      = {req, req} >> search_start;
    assign req_rot      = req_dbl[NUM_PORTS-1:0];

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found   = 1'b0;
        win_int = 0;
        win     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                win_int = int'(search_start) + k;
                if (win_int >= NUM_PORTS) win_int = win_int - NUM_PORTS;
                win     = IDX_W'(win_int);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req)      state_next = BUSY;
            BUSY:    if (bus.mem_resp) state_next = RELEASE;
            RELEASE:                   state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // NOTE: the wide address/data latches are reset too, because the memory side must see zeros right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= '0;
            rr_ptr     <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (state == IDLE && any_req) begin
            grant_q    <= win;
            op_write_q <= bus.cl_write[win];
            addr_q     <= bus.cl_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q    <= bus.cl_wdata[win*LINE_WIDTH +: LINE_WIDTH];
            if (PRIORITY_MODE != 0)
                rr_ptr <= '0;
            else
                rr_ptr <= (win == IDX_W'(NUM_PORTS - 1)) ? '0 : win + IDX_W'(1);
        end
    end

    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.grant_valid = 1'b0;
        bus.cl_resp     = '0;
        if (state == BUSY) begin
            bus.grant_valid = 1'b1;
            bus.mem_read    = ~op_write_q;
            bus.mem_write   = op_write_q;
            if (bus.mem_resp) bus.cl_resp[grant_q] = 1'b1;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.grant_idx = grant_q;
    assign bus.cl_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: 2-port round-robin, 4-port round-robin
// and 3-port fixed-priority instances exercised one after another.
module tb_mem_arbiter_rr;
    logic clk;
    logic rst2, rst4, rstf;

    int vectors;
    int miscompares;

    mem_arbiter_rr_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .LINE_WIDTH(256)) bus2 ();
    mem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .LINE_WIDTH(256)) bus4 ();
    mem_arbiter_rr_if #(.NUM_PORTS(3), .ADDR_WIDTH(32), .LINE_WIDTH(256)) busf ();

    mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(32), .LINE_WIDTH(256), .PRIORITY_MODE(0))
        dut2 (.clk(clk), .rst(rst2), .bus(bus2));
    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(32), .LINE_WIDTH(256), .PRIORITY_MODE(0))
        dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    mem_arbiter_rr #(.NUM_PORTS(3), .ADDR_WIDTH(32), .LINE_WIDTH(256), .PRIORITY_MODE(1))
        dutf (.clk(clk), .rst(rstf), .bus(busf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx;
        logic [255:0] a5_line;
        a5_line     = {32{8'hA5}};
        vectors     = 0;
        miscompares = 0;
        rst2 = 1'b1; rst4 = 1'b1; rstf = 1'b1;

        bus2.cl_read = '0; bus2.cl_write = '0; bus2.cl_addr = '0; bus2.cl_wdata = '0;
        bus2.mem_rdata = '0; bus2.mem_resp = 1'b0;
        bus4.cl_read = 4'hF; bus4.cl_write = '0; bus4.cl_wdata = '0;
        bus4.mem_rdata = '0; bus4.mem_resp = 1'b0;
        for (int i = 0; i < 4; i++) bus4.cl_addr[i*32 +: 32] = 32'h1000 * (i + 1);
        busf.cl_read = 3'b101; busf.cl_write = '0; busf.cl_addr = '0; busf.cl_wdata = '0;
        busf.mem_rdata = '0; busf.mem_resp = 1'b0;
        busf.cl_addr[0 +: 32]  = 32'hA0;
        busf.cl_addr[64 +: 32] = 32'hC0;

        repeat (2) tick();
        rst2 = 1'b0;
        tick();
        check("reset_mem_read",    256'(bus2.mem_read),    256'(0));
        check("reset_mem_write",   256'(bus2.mem_write),   256'(0));
        check("reset_grant_valid", 256'(bus2.grant_valid), 256'(0));
        check("reset_grant_idx",   256'(bus2.grant_idx),   256'(0));
        check("reset_mem_addr",    256'(bus2.mem_addr),    256'(0));
        check("reset_cl_resp",     256'(bus2.cl_resp),     256'(0));

        // Single read from client 1, response in the 4th BUSY cycle.
        bus2.cl_read = 2'b10;
        bus2.cl_addr[32 +: 32] = 32'h0000_1240;
        tick();
        check("rd_mem_read",    256'(bus2.mem_read),    256'(1));
        check("rd_mem_write",   256'(bus2.mem_write),   256'(0));
        check("rd_mem_addr",    256'(bus2.mem_addr),    256'(32'h1240));
        check("rd_grant_valid", 256'(bus2.grant_valid), 256'(1));
        check("rd_grant_idx",   256'(bus2.grant_idx),   256'(1));
        for (int c = 2; c <= 4; c++) begin
            check("rd_no_early_resp", 256'(bus2.cl_resp), 256'(0));
            tick();
        end
        bus2.mem_resp  = 1'b1;
        bus2.mem_rdata = a5_line;
        #1;
        check("rd_cl_resp",  256'(bus2.cl_resp), 256'(2'b10));
        check("rd_cl_rdata", bus2.cl_rdata,      a5_line);
        tick();
        bus2.mem_resp = 1'b0;
        #1;
        check("rd_release_resp",  256'(bus2.cl_resp),     256'(0));
        check("rd_release_read",  256'(bus2.mem_read),    256'(0));
        check("rd_release_grant", 256'(bus2.grant_valid), 256'(0));
        bus2.cl_read = '0;
        tick();
        check("rd_idle_read", 256'(bus2.mem_read), 256'(0));

        // Write from client 0 with read also high; inputs change mid-transaction.
        bus2.cl_write = 2'b01;
        bus2.cl_read  = 2'b01;
        bus2.cl_addr[0 +: 32]   = 32'h80;
        bus2.cl_wdata[0 +: 256] = 256'h1234;
        tick();
        check("wr_mem_write", 256'(bus2.mem_write), 256'(1));
        check("wr_mem_read",  256'(bus2.mem_read),  256'(0));
        check("wr_grant_idx", 256'(bus2.grant_idx), 256'(0));
        bus2.cl_addr[0 +: 32]   = 32'h100;
        bus2.cl_wdata[0 +: 256] = 256'hFFFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("wr_hold_addr",  256'(bus2.mem_addr),  256'(32'h80));
            check("wr_hold_wdata", bus2.mem_wdata,       256'h1234);
            check("wr_hold_write", 256'(bus2.mem_write), 256'(1));
        end
        bus2.mem_resp = 1'b1;
        #1;
        check("wr_cl_resp", 256'(bus2.cl_resp), 256'(2'b01));
        tick();
        bus2.mem_resp = 1'b0;
        check("wr_release_write", 256'(bus2.mem_write), 256'(0));
        bus2.cl_write = '0;
        bus2.cl_read  = '0;
        tick();

        // Reset in the 2nd BUSY cycle; rr_ptr is 1 beforehand so client 1 wins first.
        bus2.cl_read = 2'b11;
        bus2.cl_addr[0 +: 32]  = 32'h300;
        bus2.cl_addr[32 +: 32] = 32'h400;
        tick();
        check("rst_pre_grant_idx", 256'(bus2.grant_idx), 256'(1));
        check("rst_pre_mem_addr",  256'(bus2.mem_addr),  256'(32'h400));
        tick();
        rst2 = 1'b1;
        #1;
        check("rst_mid_mem_read",    256'(bus2.mem_read),    256'(0));
        check("rst_mid_grant_valid", 256'(bus2.grant_valid), 256'(0));
        check("rst_mid_grant_idx",   256'(bus2.grant_idx),   256'(0));
        check("rst_mid_mem_addr",    256'(bus2.mem_addr),    256'(0));
        bus2.cl_read = '0;
        tick();
        rst2 = 1'b0;
        bus2.mem_resp = 1'b1;
        #1;
        check("spurious_resp_cl_resp", 256'(bus2.cl_resp), 256'(0));
        tick();
        bus2.mem_resp = 1'b0;
        check("spurious_resp_idle", 256'(bus2.grant_valid), 256'(0));
        bus2.cl_read = 2'b11;
        tick();
        check("post_rst_grant_idx", 256'(bus2.grant_idx), 256'(0));
        check("post_rst_mem_addr",  256'(bus2.mem_addr),  256'(32'h300));
        check("post_rst_mem_read",  256'(bus2.mem_read),  256'(1));
        bus2.mem_resp = 1'b1;
        tick();
        bus2.mem_resp = 1'b0;
        bus2.cl_read  = '0;
        tick();

        // Four clients requesting continuously from reset: order 0,1,2,3,0.
        rst4 = 1'b0;
        for (int t = 0; t < 5; t++) begin
            exp_idx = t % 4;
            tick();
            check("rr4_grant_idx",   256'(bus4.grant_idx),   256'(exp_idx));
            check("rr4_grant_valid", 256'(bus4.grant_valid), 256'(1));
            check("rr4_mem_read",    256'(bus4.mem_read),    256'(1));
            check("rr4_mem_write",   256'(bus4.mem_write),   256'(0));
            check("rr4_mem_addr",    256'(bus4.mem_addr),    256'(32'h1000 * (exp_idx + 1)));
            bus4.mem_resp = 1'b1;
            #1;
            check("rr4_cl_resp", 256'(bus4.cl_resp), 256'(4'b0001 << exp_idx));
            tick();
            bus4.mem_resp = 1'b0;
            check("rr4_release_read", 256'(bus4.mem_read),    256'(0));
            check("rr4_release_gv",   256'(bus4.grant_valid), 256'(0));
            tick();
            check("rr4_idle_read", 256'(bus4.mem_read), 256'(0));
        end
        bus4.cl_read = '0;

        // Fixed priority: client 0 beats client 2 until it drops.
        rstf = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("fp_grant_idx", 256'(busf.grant_idx), 256'(0));
            check("fp_mem_addr",  256'(busf.mem_addr),  256'(32'hA0));
            busf.mem_resp = 1'b1;
            #1;
            check("fp_cl_resp", 256'(busf.cl_resp), 256'(3'b001));
            tick();
            busf.mem_resp = 1'b0;
            tick();
        end
        busf.cl_read = 3'b100;
        tick();
        check("fp_after_drop_idx",  256'(busf.grant_idx), 256'(2));
        check("fp_after_drop_addr", 256'(busf.mem_addr),  256'(32'hC0));
        busf.mem_resp = 1'b1;
        #1;
        check("fp_after_drop_resp", 256'(busf.cl_resp), 256'(3'b100));
        tick();
        busf.mem_resp = 1'b0;
        busf.cl_read  = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
